// File: rtl/scaled_updown_counter_if.sv
// Control/status bundle for scaled_updown_counter: the master drives the count
// controls, and the slave (the counter) returns the count and the timebase outputs.
interface scaled_updown_counter_if #(
    parameter int unsigned WIDTH = 15
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             div_out;
    logic             tick;
    logic             tc;

    modport master (
        output en, up_dn, load, load_val,
        input  count, div_out, tick, tc
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, div_out, tick, tc
    );
endinterface

// File: rtl/scaled_updown_counter.sv
// Prescaled up/down counter: a square-wave divided clock, plus a WIDTH-bit counter that steps on each div_out rise.
// Define UDC_SAT_EN to make the counter saturate at its limits instead of wrapping.
module scaled_updown_counter #(
    parameter int unsigned WIDTH    = 15,
    parameter int unsigned DIV_HALF = 32,
    parameter int unsigned PRE_W    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    scaled_updown_counter_if.slave  bus
);

    localparam int unsigned PRE_LAST = DIV_HALF - 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             div_out_q, div_out_d;
    logic             tick_q,    tick_d;
    logic             tc_q,      tc_d;
    logic [WIDTH-1:0] count_q,   count_d;

    logic pre_last;
    logic step;

    assign pre_last = (pre_cnt_q == PRE_W'(PRE_LAST));
    // A step is the cycle in which div_out is about to rise.
    assign step     = pre_last && !div_out_q;

    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        div_out_d = div_out_q;
        tick_d    = step;
        tc_d      = 1'b0;
        count_d   = count_q;

        if (pre_last) begin
            pre_cnt_d = '0;
            div_out_d = ~div_out_q;
        end

        // Load overrides any step and ignores en.
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (step && bus.en) begin
            if (bus.up_dn) begin
                if (count_q == CNT_MAX) begin
                    tc_d = 1'b1;
`ifdef UDC_SAT_EN
                    count_d = CNT_MAX;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
`ifdef UDC_SAT_EN
                    count_d = '0;
`else
                    count_d = CNT_MAX;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            count_q   <= count_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.div_out = div_out_q;
    assign bus.tick    = tick_q;
    assign bus.tc      = tc_q;

endmodule

// File: tb/tb_scaled_updown_counter.sv
// Scoreboard bench for scaled_updown_counter: instance A (WIDTH=4, DIV_HALF=4) is checked against queued
// per-tick expectations, and instance B (WIDTH=4, DIV_HALF=1) is checked every cycle against an edge-indexed model.
module tb_scaled_updown_counter;

`ifdef UDC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   edge_n = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    typedef struct {
        int at_edge;
        int count;
        int tc;
    } exp_t;

    exp_t exp_q[$];

    scaled_updown_counter_if #(.WIDTH(4)) if_a ();
    scaled_updown_counter_if #(.WIDTH(4)) if_b ();

    scaled_updown_counter #(.WIDTH(4), .DIV_HALF(4), .PRE_W(3)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    scaled_updown_counter #(.WIDTH(4), .DIV_HALF(1), .PRE_W(1)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    // Edge index: the first edge with reset low is edge 1.
    always @(posedge clk) edge_n <= reset ? 0 : edge_n + 1;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    endfunction

    task automatic push(int e, int c, int t);
        exp_t x;
        x.at_edge = e;
        x.count   = c;
        x.tc      = t;
        exp_q.push_back(x);
    endtask

    task automatic goto(int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Instance A monitor: each tick pops one expectation.
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            if (if_a.tick) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL a_unexpected_tick at edge %0d: got tick with count %0d, expected no tick",
                             edge_n, if_a.count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("a_tick_edge", edge_n, e.at_edge);
                    chk("a_tick_count", int'(if_a.count), e.count);
                    chk("a_tick_tc", int'(if_a.tc), e.tc);
                    chk("a_tick_div_out", int'(if_a.div_out), 1);
                end
            end else begin
                chk("a_tc_idle", int'(if_a.tc), 0);
            end
        end
    end

    // Instance B model: a tick on every odd edge; count k=(edge+1)/2 wraps or saturates.
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            int k;
            int exp_tick;
            int exp_cnt;
            int exp_tc;
            k        = (edge_n + 1) / 2;
            exp_tick = edge_n % 2;
            exp_cnt  = SAT ? ((k > 15) ? 15 : k) : (k % 16);
            exp_tc   = (exp_tick == 1) && (SAT ? (k >= 16) : (k % 16 == 0));
            chk("b_tick", int'(if_b.tick), exp_tick);
            chk("b_count", int'(if_b.count), exp_cnt);
            chk("b_tc", int'(if_b.tc), exp_tc);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if_a.en = 1'b1; if_a.up_dn = 1'b1; if_a.load = 1'b0; if_a.load_val = '0;
        if_b.en = 1'b1; if_b.up_dn = 1'b1; if_b.load = 1'b0; if_b.load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_count", int'(if_a.count), 0);
        chk("rst_a_div_out", int'(if_a.div_out), 0);
        chk("rst_a_tick", int'(if_a.tick), 0);
        chk("rst_a_tc", int'(if_a.tc), 0);
        reset = 1'b0;

        // Free-running count up from reset.
        push(4, 1, 0);
        push(12, 2, 0);
        push(20, 3, 0);
        goto(7);
        chk("a_div_high", int'(if_a.div_out), 1);
        goto(8);
        chk("a_div_fall", int'(if_a.div_out), 0);

        // Up wrap from 15.
        goto(21);
        if_a.load = 1'b1; if_a.load_val = 4'd15;
        goto(22);
        if_a.load = 1'b0;
        chk("a_load15", int'(if_a.count), 15);
        push(28, SAT ? 15 : 0, 1);
        push(36, SAT ? 15 : 1, SAT ? 1 : 0);
        goto(29);
        chk("a_after_wrap_count", int'(if_a.count), SAT ? 15 : 0);
        chk("a_after_wrap_tc", int'(if_a.tc), 0);

        // Down wrap from 0.
        goto(37);
        if_a.load = 1'b1; if_a.load_val = 4'd0; if_a.up_dn = 1'b0;
        goto(38);
        if_a.load = 1'b0;
        chk("a_load0", int'(if_a.count), 0);
        push(44, SAT ? 0 : 15, 1);
        push(52, SAT ? 0 : 14, SAT ? 1 : 0);
        push(60, SAT ? 0 : 13, SAT ? 1 : 0);

        // Load coincident with a step.
        goto(61);
        if_a.load = 1'b1; if_a.load_val = 4'd3; if_a.up_dn = 1'b1;
        goto(62);
        if_a.load = 1'b0;
        chk("a_load3", int'(if_a.count), 3);
        push(68, 9, 0);
        goto(67);
        if_a.load = 1'b1; if_a.load_val = 4'd9;
        goto(68);
        if_a.load = 1'b0;
        chk("a_load_step_count", int'(if_a.count), 9);
        chk("a_load_step_div", int'(if_a.div_out), 1);

        // en low across three steps, then one enabled step.
        if_a.en = 1'b0;
        push(76, 9, 0);
        push(84, 9, 0);
        push(92, 9, 0);
        goto(92);
        if_a.en = 1'b1;
        push(100, 10, 0);
        goto(100);
        if_a.en = 1'b0;

        // Reset in the middle of a high half-period.
        goto(101);
        if_a.load = 1'b1; if_a.load_val = 4'd7;
        goto(102);
        if_a.load = 1'b0;
        push(108, 7, 0);
        goto(110);
        chk("a_pre_reset_div", int'(if_a.div_out), 1);
        chk("a_pre_reset_count", int'(if_a.count), 7);
        reset = 1'b1;
        if_a.load = 1'b1; if_a.load_val = 4'd5;
        @(posedge clk);
        #1;
        chk("midrst_a_count", int'(if_a.count), 0);
        chk("midrst_a_div_out", int'(if_a.div_out), 0);
        chk("midrst_a_tick", int'(if_a.tick), 0);
        chk("midrst_a_tc", int'(if_a.tc), 0);
        chk("midrst_b_count", int'(if_b.count), 0);
        chk("midrst_b_div_out", int'(if_b.div_out), 0);
        reset = 1'b0;
        if_a.load = 1'b0;
        if_a.en = 1'b1;
        push(4, 1, 0);
        goto(5);
        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
